// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit-side control blocks.
//   arb_state_t       : arbiter FSM states
//   UART_WORD_LENGTH  : data bits per UART frame (mirrors WORD_LENGTH in globals.vh)
//   DEF_ACK_TIMEOUT   : default cycles to wait for the transmitter to go busy
package uart_ctrl_pkg;

  localparam int unsigned UART_WORD_LENGTH = 8;
  localparam int unsigned DEF_ACK_TIMEOUT  = 64;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    RECOVER
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search.
//   req_valid : pending-request vector
//   rr_ptr    : index searched first; search continues upward modulo NUM_REQ
//   any_valid : at least one request pending
//   winner    : first pending index found from rr_ptr (0 when none pending)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       any_valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Modulo on the widened sum keeps the wrap correct for non-power-of-two NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the UART transmitter among NUM_REQ byte producers.
//   t_clk, t_rst       : transmit clock, synchronous active-low reset
//   req_valid/req_data : per-requester pending flag and byte
//   req_ready          : one-hot pulse when a requester's byte is captured
//   UART_Tx_RQST       : transmit request, Tx_DATA held while in flight
//   UART_Tx_READY_BUSY : 1 = transmitter idle, 0 = busy
//   grant_id           : current/last granted requester
//   arb_busy           : arbiter not idle
//   tx_err             : pulse when the transmitter never acknowledged a request
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WORD_LENGTH = UART_WORD_LENGTH,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                           t_clk,
  input  logic                           t_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           UART_Tx_RQST,
  output logic [WORD_LENGTH-1:0]         Tx_DATA,
  input  logic                           UART_Tx_READY_BUSY,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           arb_busy,
  output logic                           tx_err
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt, next_ptr, winner;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             any_valid, grant, err_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any_valid (any_valid),
    .winner    (winner)
  );

  // Explicit wrap so non-power-of-two NUM_REQ never reaches an unused index.
  assign next_ptr = (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rr_ptr_nxt = rr_ptr;
    grant      = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid && UART_Tx_READY_BUSY) begin
          grant     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_nxt = cnt + 1'b1;
        if (!UART_Tx_READY_BUSY) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = RECOVER;
        end
      end
      WAIT_DONE: begin
        if (UART_Tx_READY_BUSY) begin
          rr_ptr_nxt = next_ptr;
          state_nxt  = IDLE;
        end
      end
      RECOVER: begin
        rr_ptr_nxt = next_ptr;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decision, so req_ready, Tx_DATA,
  // grant_id and UART_Tx_RQST all become visible together on the cycle after
  // the grant decision.
  always_ff @(posedge t_clk) begin
    if (!t_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= '0;
      req_ready    <= '0;
      UART_Tx_RQST <= 1'b0;
      Tx_DATA      <= '0;
      grant_id     <= '0;
      arb_busy     <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rr_ptr       <= rr_ptr_nxt;
      UART_Tx_RQST <= (state_nxt == LAUNCH);
      arb_busy     <= (state_nxt != IDLE);
      tx_err       <= err_nxt;
      req_ready    <= grant ? (ONE << winner) : '0;
      if (grant) begin
        Tx_DATA  <= req_data[winner*WORD_LENGTH +: WORD_LENGTH];
        grant_id <= winner;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: producer queues, a transmitter model
// and a transaction-level reference predicting every registered output per cycle.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;
  localparam int M_IDLE = 0, M_REQ = 1, M_XMIT = 2, M_REC = 3;

  logic           t_clk = 1'b0;
  logic           t_rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           UART_Tx_RQST;
  logic [W-1:0]   Tx_DATA;
  logic           UART_Tx_READY_BUSY;
  logic [1:0]     grant_id;
  logic           arb_busy, tx_err;

  logic [2:0]  v3, rr3;
  logic [23:0] d3;
  logic        rq3, rdy3, bsy3, err3;
  logic [7:0]  dat3;
  logic [1:0]  gid3;

  uart_tx_arbiter #(.NUM_REQ(N), .WORD_LENGTH(W), .ACK_TIMEOUT(TO)) dut (
    .t_clk(t_clk), .t_rst(t_rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .UART_Tx_RQST(UART_Tx_RQST), .Tx_DATA(Tx_DATA),
    .UART_Tx_READY_BUSY(UART_Tx_READY_BUSY), .grant_id(grant_id),
    .arb_busy(arb_busy), .tx_err(tx_err)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .WORD_LENGTH(8), .ACK_TIMEOUT(64)) dut3 (
    .t_clk(t_clk), .t_rst(t_rst), .req_valid(v3), .req_data(d3),
    .req_ready(rr3), .UART_Tx_RQST(rq3), .Tx_DATA(dat3),
    .UART_Tx_READY_BUSY(rdy3), .grant_id(gid3),
    .arb_busy(bsy3), .tx_err(err3)
  );

  always #5 t_clk = ~t_clk;

  int n_err = 0, n_chk = 0, cyc = 0;

  // producers, logs, transmitter model, reference model state
  logic [7:0] pq [N][$];
  int g_id[$], g_data[$], g_cyc[$], g_rdy[$], g_rq[$], log3[$], log3d[$];
  int rise_cyc, err_cyc, err_rqst, n_txerr = 0;
  bit prev_rqst, xrdy, x_ignore, never_ack, force_busy, rand_mode, rst_drv, en3;
  int xa, xb, a_cur, b_cur, x_ack = 2, x_busy = 4, r3;
  logic [N-1:0]   s_valid;
  logic [N*W-1:0] s_data;
  bit             s_rdy, s_rst;
  int m_mode, m_ptr, m_age, e_gid;
  logic [N-1:0] e_ready;
  logic [7:0]   e_data;
  bit e_rqst, e_busy, e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_seq(input string tag, input int got[$], input int exp[$], input bit exact);
    if (exact) chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    else       chk({tag, "_len"}, 32'(got.size() >= exp.size()), 32'd1);
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  function automatic int exp_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Reference: one transaction at a time; m_age counts edges spent requesting.
  task automatic model_step();
    int w;
    e_ready = '0;
    e_err   = 1'b0;
    if (!s_rst) begin
      m_mode = M_IDLE; m_ptr = 0; m_age = 0;
      e_data = '0; e_gid = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s_valid != '0 && s_rdy) begin
          w = exp_winner(s_valid, m_ptr);
          e_ready[w] = 1'b1;
          e_data = s_data[w*W +: W];
          e_gid  = w;
          m_mode = M_REQ;
          m_age  = 0;
        end
        M_REQ: begin
          m_age++;
          if (!s_rdy) m_mode = M_XMIT;
          else if (m_age == TO) begin e_err = 1'b1; m_mode = M_REC; end
        end
        M_XMIT: if (s_rdy) begin m_ptr = (e_gid + 1) % N; m_mode = M_IDLE; end
        default: begin m_ptr = (e_gid + 1) % N; m_mode = M_IDLE; end
      endcase
    end
    e_rqst = (m_mode == M_REQ);
    e_busy = (m_mode != M_IDLE);
  endtask

  task automatic xmtr_step();
    if (req_ready != '0) x_ignore = rand_mode ? ($urandom_range(0, 9) == 0) : never_ack;
    if (!rst_drv) begin
      xrdy = 1'b1; xa = 0; xb = 0; rdy3 = 1'b1; r3 = 0;
    end else begin
      if (xb > 0) begin
        xb--; if (xb == 0) xrdy = 1'b1;
      end else if (xa > 0) begin
        xa--; if (xa == 0) begin xrdy = 1'b0; xb = b_cur; end
      end else if (UART_Tx_RQST && xrdy && !x_ignore) begin
        a_cur = rand_mode ? int'($urandom_range(1, 4)) : x_ack;
        b_cur = rand_mode ? int'($urandom_range(1, 12)) : x_busy;
        xa = a_cur;
      end
      if (r3 > 0) begin
        r3--; if (r3 == 0) rdy3 = 1'b1;
      end else if (rq3 && rdy3) begin
        rdy3 = 1'b0; r3 = 2;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pq[i].size() != 0);
      req_data[i*W +: W] = (pq[i].size() != 0) ? pq[i][0] : 8'($urandom);
    end
    if (rand_mode) force_busy = ($urandom_range(0, 7) == 0);
    UART_Tx_READY_BUSY = xrdy && !force_busy;
    t_rst = rst_drv;
    v3 = en3 ? 3'b111 : 3'b000;
    s_valid = req_valid; s_data = req_data; s_rdy = UART_Tx_READY_BUSY; s_rst = t_rst;
  endtask

  task automatic cycle();
    int j;
    @(negedge t_clk);
    cyc++;
    model_step();
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("rqst", 32'(UART_Tx_RQST), 32'(e_rqst));
    chk("tx_data", 32'(Tx_DATA), 32'(e_data));
    chk("grant_id", 32'(grant_id), 32'(e_gid));
    chk("arb_busy", 32'(arb_busy), 32'(e_busy));
    chk("tx_err", 32'(tx_err), 32'(e_err));
    if (req_ready != '0) begin
      g_id.push_back(int'(grant_id)); g_data.push_back(int'(Tx_DATA));
      g_cyc.push_back(cyc); g_rdy.push_back(int'(req_ready)); g_rq.push_back(int'(UART_Tx_RQST));
    end
    if (UART_Tx_RQST && !prev_rqst) rise_cyc = cyc;
    prev_rqst = UART_Tx_RQST;
    if (tx_err) begin err_cyc = cyc; err_rqst = int'(UART_Tx_RQST); n_txerr++; end
    if (en3 && rr3 != '0) begin log3.push_back(int'(gid3)); log3d.push_back(int'(dat3)); end
    for (int i = 0; i < N; i++)
      if (req_ready[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    if (rand_mode && $urandom_range(0, 2) == 0) begin
      j = int'($urandom_range(0, N - 1));
      if (pq[j].size() < 3) pq[j].push_back(8'($urandom));
    end
    xmtr_step();
    drive();
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input string tag, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      cycle();
      done = queues_empty() && !arb_busy;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic clear_logs();
    g_id.delete(); g_data.delete(); g_cyc.delete(); g_rdy.delete(); g_rq.delete();
    log3.delete(); log3d.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rel, gap, e0;
    bit seen, bad;
    xrdy = 1'b1; rdy3 = 1'b1; rst_drv = 1'b0; d3 = {8'h32, 8'h31, 8'h30};
    drive();
    repeat (3) cycle();
    chk("rst_rqst", 32'(UART_Tx_RQST), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    rst_drv = 1'b1;
    cycle();

    // single requester
    clear_logs(); x_ack = 3; x_busy = 20;
    pq[2].push_back(8'hA5); t0 = cyc;
    run_idle("t1_done", 200);
    chk_seq("t1_id", g_id, {2}, 1'b1);
    chk_seq("t1_data", g_data, {8'hA5}, 1'b1);
    chk_seq("t1_rdy", g_rdy, {4'b0100}, 1'b1);
    chk_seq("t1_rq", g_rq, {1}, 1'b1);
    if (g_cyc.size() > 0) chk("t1_lat", 32'(g_cyc[0] - t0), 32'd2);

    // fairness and wrap from rr_ptr=3
    clear_logs(); x_ack = 1; x_busy = 5;
    for (int i = 0; i < N; i++) pq[i].push_back(8'(8'h10 + i));
    pq[3].push_back(8'h13);
    run_idle("t2_done", 300);
    chk_seq("t2_id", g_id, {3, 0, 1, 2, 3}, 1'b1);
    chk_seq("t2_data", g_data, {8'h13, 8'h10, 8'h11, 8'h12, 8'h13}, 1'b1);

    // transmitter busy while a request waits
    clear_logs(); force_busy = 1'b1;
    pq[0].push_back(8'h5C);
    repeat (50) cycle();
    chk("t3_nogrant", 32'(g_id.size()), 32'd0);
    force_busy = 1'b0;
    cycle(); rel = cyc;
    run_idle("t3_done", 100);
    if (g_cyc.size() > 0) chk("t3_lat", 32'(g_cyc[0] - rel), 32'd1);
    chk_seq("t3_data", g_data, {8'h5C}, 1'b1);

    // acknowledge timeout
    clear_logs(); never_ack = 1'b1; e0 = n_txerr; seen = 1'b0; gap = 0;
    pq[1].push_back(8'hE1); pq[2].push_back(8'hE2);
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle();
      if (n_txerr > e0) begin seen = 1'b1; gap = err_cyc - rise_cyc; end
    end
    chk("t4_seen", 32'(seen), 32'd1);
    chk("t4_gap", 32'(gap), 32'(TO));
    chk("t4_rqst_low", 32'(err_rqst), 32'd0);
    never_ack = 1'b0;
    run_idle("t4_done", 200);
    chk_seq("t4_id", g_id, {1, 2}, 1'b1);
    chk_seq("t4_data", g_data, {8'hE1, 8'hE2}, 1'b1);
    chk("t4_errs", 32'(n_txerr - e0), 32'd1);

    // reset during WAIT_DONE
    clear_logs(); x_ack = 2; x_busy = 20; seen = 1'b0; e0 = n_txerr;
    pq[3].push_back(8'h77);
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      seen = (g_id.size() > 0) && arb_busy && !UART_Tx_RQST;
    end
    chk("t5_wait", 32'(seen), 32'd1);
    pq[2].push_back(8'h92); pq[3].push_back(8'h88);
    rst_drv = 1'b0;
    cycle(); cycle();
    chk("t5_busy", 32'(arb_busy), 32'd0);
    chk("t5_rqst", 32'(UART_Tx_RQST), 32'd0);
    chk("t5_data", 32'(Tx_DATA), 32'd0);
    chk("t5_gid", 32'(grant_id), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    rst_drv = 1'b1; clear_logs();
    run_idle("t5_done", 200);
    chk_seq("t5_id", g_id, {2, 3}, 1'b1);
    chk_seq("t5_d", g_data, {8'h92, 8'h88}, 1'b1);
    chk("t5_noerr", 32'(n_txerr - e0), 32'd0);

    // three-requester build wraps 0,1,2,0
    clear_logs(); en3 = 1'b1;
    repeat (40) cycle();
    en3 = 1'b0;
    chk_seq("nr3_id", log3, {0, 1, 2, 0}, 1'b0);
    chk_seq("nr3_data", log3d, {8'h30, 8'h31, 8'h32, 8'h30}, 1'b0);
    bad = 1'b0;
    foreach (log3[i]) if (log3[i] >= 3) bad = 1'b1;
    chk("nr3_range", 32'(bad), 32'd0);
    repeat (10) cycle();

    // randomized traffic against the reference model
    rand_mode = 1'b1;
    repeat (2000) cycle();
    rand_mode = 1'b0; force_busy = 1'b0;
    run_idle("rand_drain", 600);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
